// File: rtl/elastic_buffer.sv
// Elastic buffer: a DEPTH-slot circular FIFO carrying {data, keep, last} beats
// with registered-only ready/valid, synchronous flush and fill reporting.
module elastic_buffer #(
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int DEPTH        = 2,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic [KEEP_WIDTH-1:0]      in_keep,
    input  logic                       in_last,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [KEEP_WIDTH-1:0]      out_keep,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       almost_full
);

    // Handshake: a beat moves on a rising edge where valid && ready are both
    // high and flush is low; ready never looks at the opposite side's ports.

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = DATA_WIDTH + KEEP_WIDTH + 1;

    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);

    logic [SW-1:0] slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          init_done;
    logic          push;
    logic          pop;

    // Explicit wrap so non-power-of-two depths never index past the last slot.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    assign in_ready    = init_done && (count < DEPTH_C) && !flush;
    assign out_valid   = (count != '0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready && !flush;
    assign fill_level  = count;
    assign almost_full = (count >= AFULL_C);

    assign {out_data, out_keep, out_last} = slots[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            init_done <= 1'b1;
            count     <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Payload storage is deliberately unreset; out_* only matter while out_valid.
    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= {in_data, in_keep, in_last};
    end

endmodule

// File: tb/tb_elastic_buffer.sv
// Randomised scoreboard bench for elastic_buffer: a DEPTH=4 instance for the
// main scenarios and a DEPTH=3 instance for pointer-wrap ordering.
module tb_elastic_buffer;

    localparam int DW = 16;
    localparam int KW = 2;
    localparam int W  = DW + KW + 1;

    logic clk;
    logic rst_n;

    logic          flush_a, in_valid_a, in_ready_a, in_last_a;
    logic          out_valid_a, out_ready_a, out_last_a, almost_full_a;
    logic [DW-1:0] in_data_a, out_data_a;
    logic [KW-1:0] in_keep_a, out_keep_a;
    logic [2:0]    fill_level_a;

    logic          flush_b, in_valid_b, in_ready_b, in_last_b;
    logic          out_valid_b, out_ready_b, out_last_b, almost_full_b;
    logic [DW-1:0] in_data_b, out_data_b;
    logic [KW-1:0] in_keep_b, out_keep_b;
    logic [1:0]    fill_level_b;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];

    int tests = 0;
    int fails = 0;

    elastic_buffer #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(4), .AFULL_THRESH(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a),
        .in_data(in_data_a), .in_keep(in_keep_a), .in_last(in_last_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_keep(out_keep_a), .out_last(out_last_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .fill_level(fill_level_a), .almost_full(almost_full_a)
    );

    elastic_buffer #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b),
        .in_data(in_data_b), .in_keep(in_keep_b), .in_last(in_last_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_keep(out_keep_b), .out_last(out_last_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .fill_level(fill_level_b), .almost_full(almost_full_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor A (DEPTH=4, thresh 3) ----------------
    int           cnt_a  = 0;
    bit           init_a = 0;
    bit           stall_a = 0;
    logic [W-1:0] held_a;

    always @(negedge clk) begin
        bit           exp_rdy;
        bit           popped;
        logic [W-1:0] got;
        if (!rst_n) begin
            cnt_a = 0; init_a = 0; stall_a = 0;
        end else begin
            exp_rdy = init_a && (cnt_a < 4) && !flush_a;
            got     = {out_data_a, out_keep_a, out_last_a};
            check("a_in_ready", W'(in_ready_a), W'(exp_rdy));
            check("a_fill_level", W'(fill_level_a), W'(cnt_a));
            check("a_almost_full", W'(almost_full_a), W'(cnt_a >= 3));
            check("a_out_valid", W'(out_valid_a), W'(cnt_a != 0));
            if (stall_a) check("a_stall_stable", got, held_a);
            if (flush_a) begin
                exp_a.delete();
                cnt_a = 0; stall_a = 0;
            end else begin
                popped = (cnt_a != 0) && out_ready_a;
                if (popped) begin
                    if (exp_a.size() == 0) check("a_unexpected_beat", got, 'x);
                    else check("a_beat", got, exp_a.pop_front());
                end
                stall_a = (cnt_a != 0) && !out_ready_a;
                held_a  = got;
                cnt_a   = cnt_a + int'(in_valid_a && exp_rdy) - int'(popped);
            end
            init_a = 1;
        end
    end

    // ---------------- monitor B (DEPTH=3, thresh 2) ----------------
    int           cnt_b  = 0;
    bit           init_b = 0;
    bit           stall_b = 0;
    logic [W-1:0] held_b;

    always @(negedge clk) begin
        bit           exp_rdy;
        bit           popped;
        logic [W-1:0] got;
        if (!rst_n) begin
            cnt_b = 0; init_b = 0; stall_b = 0;
        end else begin
            exp_rdy = init_b && (cnt_b < 3) && !flush_b;
            got     = {out_data_b, out_keep_b, out_last_b};
            check("b_in_ready", W'(in_ready_b), W'(exp_rdy));
            check("b_fill_level", W'(fill_level_b), W'(cnt_b));
            check("b_almost_full", W'(almost_full_b), W'(cnt_b >= 2));
            check("b_out_valid", W'(out_valid_b), W'(cnt_b != 0));
            if (stall_b) check("b_stall_stable", got, held_b);
            popped = (cnt_b != 0) && out_ready_b;
            if (popped) begin
                if (exp_b.size() == 0) check("b_unexpected_beat", got, 'x);
                else check("b_beat", got, exp_b.pop_front());
            end
            stall_b = (cnt_b != 0) && !out_ready_b;
            held_b  = got;
            cnt_b   = cnt_b + int'(in_valid_b && exp_rdy) - int'(popped);
            init_b  = 1;
        end
    end

    // ---------------- drivers ----------------
    // mode 0: out_ready=1; 1: out_ready=0 for 6 cycles then 1;
    // 2: random valid/ready; 3: out_ready=0 throughout.
    task automatic send_a(input int n, input int mode, input logic [DW-1:0] base);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < n * 20 + 50) begin
            in_valid_a  = (mode == 2) ? ($urandom_range(0, 99) < 70) : 1'b1;
            in_data_a   = (mode == 2) ? DW'($urandom) : base + DW'(sent);
            in_keep_a   = KW'($urandom);
            in_last_a   = 1'($urandom);
            out_ready_a = (mode == 2) ? 1'($urandom_range(0, 1)) :
                          (mode == 1) ? (cyc >= 6) : (mode == 0);
            @(negedge clk);
            if (mode == 1 && cyc == 5) begin
                check("fill_full_level", W'(fill_level_a), W'(4));
                check("fill_full_afull", W'(almost_full_a), W'(1));
                check("fill_full_ready", W'(in_ready_a), W'(0));
            end
            if (in_valid_a && in_ready_a) begin
                exp_a.push_back({in_data_a, in_keep_a, in_last_a});
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid_a = 1'b0;
        if (sent < n) check("a_send_timeout", W'(sent), W'(n));
    endtask

    task automatic drain_a();
        int cyc = 0;
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        while (exp_a.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        if (exp_a.size() != 0) check("a_drain_timeout", W'(exp_a.size()), W'(0));
        tick();
    endtask

    task automatic send_b(input int n, input int pat, input logic [DW-1:0] base);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < n * 20 + 50) begin
            in_valid_b  = 1'b1;
            in_data_b   = base + DW'(sent);
            in_keep_b   = KW'($urandom);
            in_last_b   = 1'($urandom);
            out_ready_b = (pat == 0) ? ((cyc % 5) >= 3) : ((cyc % 3) != 0);
            @(negedge clk);
            if (in_valid_b && in_ready_b) begin
                exp_b.push_back({in_data_b, in_keep_b, in_last_b});
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid_b = 1'b0;
        if (sent < n) check("b_send_timeout", W'(sent), W'(n));
    endtask

    task automatic drain_b();
        int cyc = 0;
        in_valid_b  = 1'b0;
        out_ready_b = 1'b1;
        while (exp_b.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        if (exp_b.size() != 0) check("b_drain_timeout", W'(exp_b.size()), W'(0));
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0;
        in_data_a = '0; in_keep_a = '0; in_last_a = 1'b0;
        flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
        in_data_b = '0; in_keep_b = '0; in_last_b = 1'b0;

        repeat (3) tick();
        check("reset_in_ready", W'(in_ready_a), W'(0));
        check("reset_out_valid", W'(out_valid_a), W'(0));
        check("reset_fill_level", W'(fill_level_a), W'(0));
        check("reset_almost_full", W'(almost_full_a), W'(0));
        rst_n = 1'b1;
        tick();

        // streaming 0x01..0x10
        send_a(16, 0, 16'h0001);
        drain_a();

        // fill / drain with the fifth beat waiting for space
        send_a(5, 1, 16'h0020);
        drain_a();

        // random backpressure
        send_a(1000, 2, 16'h0000);
        drain_a();

        // flush with three beats stored and a concurrent push offered
        send_a(3, 3, 16'h0100);
        in_valid_a = 1'b1;
        in_data_a  = 16'hdead;
        flush_a    = 1'b1;
        tick();
        flush_a    = 1'b0;
        in_valid_a = 1'b0;
        @(negedge clk);
        check("flush_fill_level", W'(fill_level_a), W'(0));
        check("flush_out_valid", W'(out_valid_a), W'(0));
        tick();
        send_a(6, 0, 16'h0200);
        drain_a();

        // wrap on DEPTH=3
        send_b(10, 0, 16'h0300);
        send_b(10, 1, 16'h0310);
        drain_b();

        // asynchronous reset pulse between edges with beats stored
        send_a(3, 3, 16'h0400);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", W'(out_valid_a), W'(0));
        check("arst_in_ready", W'(in_ready_a), W'(0));
        check("arst_fill_level", W'(fill_level_a), W'(0));
        check("arst_almost_full", W'(almost_full_a), W'(0));
        exp_a.delete();
        exp_b.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_release_ready_low", W'(in_ready_a), W'(0));
        tick();
        @(negedge clk);
        check("arst_release_ready_high", W'(in_ready_a), W'(1));
        tick();
        send_a(8, 0, 16'h0500);
        drain_a();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
